// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier front-end: element width,
// loader state encoding and the packed-bus slot offset helper.
package matrix_pkg;

  localparam int ELEM_W = 8;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Bit offset of element slot k within a packed matrix bus.
  function automatic int slot_off(input int k);
    return k * ELEM_W;
  endfunction

endpackage

// File: rtl/matrix_stream_loader.sv
// Assembles a row-major byte stream (A then B) into packed N*N matrix buses,
// checks frame boundaries with s_last and hands the pair off via valid/ready.
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int N = 2,
  parameter int W = ELEM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [W-1:0]     s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             abort,
  output logic [N*N*W-1:0] mat_a,
  output logic [N*N*W-1:0] mat_b,
  output logic             mat_valid,
  input  logic             mat_ready,
  output logic             err
);

  localparam int NN    = N * N;
  localparam int FRAME = 2 * NN;
  localparam int IW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [IW-1:0] A_END    = IW'(NN - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME - 1);

  state_t           state_reg;
  logic [IW-1:0]    idx_reg;
  logic             s_ready_reg;
  logic             mat_valid_reg;
  logic             err_reg;
  logic [NN*W-1:0]  mat_a_reg, mat_a_next;
  logic [NN*W-1:0]  mat_b_reg, mat_b_next;

  logic accept;
  logic early_last;
  logic wr_a;
  logic wr_b;

  // abort suppresses acceptance so nothing is written on an abort cycle.
  assign accept     = s_valid && s_ready_reg && !abort;
  assign early_last = s_last && (idx_reg != LAST_IDX);
  assign wr_a       = accept && (state_reg == LOAD_A) && !early_last;
  assign wr_b       = accept && (state_reg == LOAD_B) && !early_last;

  // Per-slot write muxes: A slots hit at index k, B slots at index k+N*N.
  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_slot
      assign mat_a_next[slot_off(gi) +: W] =
        (wr_a && (idx_reg == IW'(gi))) ? s_data : mat_a_reg[slot_off(gi) +: W];
      assign mat_b_next[slot_off(gi) +: W] =
        (wr_b && (idx_reg == IW'(gi + NN))) ? s_data : mat_b_reg[slot_off(gi) +: W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= LOAD_A;
      idx_reg       <= '0;
      s_ready_reg   <= 1'b0;
      mat_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      mat_a_reg     <= '0;
      mat_b_reg     <= '0;
    end else begin
      err_reg   <= 1'b0;
      mat_a_reg <= mat_a_next;
      mat_b_reg <= mat_b_next;
      if (abort) begin
        state_reg     <= LOAD_A;
        idx_reg       <= '0;
        mat_valid_reg <= 1'b0;
        s_ready_reg   <= 1'b1;
      end else begin
        case (state_reg)
          LOAD_A: begin
            s_ready_reg <= 1'b1;
            if (accept) begin
              if (early_last) begin
                err_reg <= 1'b1;
                idx_reg <= '0;
              end else begin
                idx_reg <= idx_reg + IW'(1);
                if (idx_reg == A_END) state_reg <= LOAD_B;
              end
            end
          end
          LOAD_B: begin
            if (accept) begin
              if (early_last) begin
                err_reg   <= 1'b1;
                idx_reg   <= '0;
                state_reg <= LOAD_A;
              end else if (idx_reg == LAST_IDX) begin
                idx_reg <= '0;
                if (s_last) begin
                  state_reg     <= PRESENT;
                  mat_valid_reg <= 1'b1;
                  s_ready_reg   <= 1'b0;
                end else begin
                  err_reg   <= 1'b1;
                  state_reg <= DRAIN;
                end
              end else begin
                idx_reg <= idx_reg + IW'(1);
              end
            end
          end
          PRESENT: begin
            if (mat_ready) begin
              mat_valid_reg <= 1'b0;
              s_ready_reg   <= 1'b1;
              state_reg     <= LOAD_A;
            end
          end
          DRAIN: begin
            s_ready_reg <= 1'b1;
            if (accept && s_last) state_reg <= LOAD_A;
          end
          default: begin
            state_reg <= LOAD_A;
            idx_reg   <= '0;
          end
        endcase
      end
    end
  end

  assign s_ready   = s_ready_reg;
  assign mat_valid = mat_valid_reg;
  assign err       = err_reg;
  assign mat_a     = mat_a_reg;
  assign mat_b     = mat_b_reg;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed and randomized bench for matrix_stream_loader (N=2) against a
// frame-level reference model built from byte lists.
module tb_matrix_stream_loader;

  localparam int N  = 2;
  localparam int NN = N * N;
  localparam int BW = NN * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          abort = 1'b0;
  logic [BW-1:0] mat_a, mat_b;
  logic          mat_valid;
  logic          mat_ready = 1'b0;
  logic          err;

  matrix_stream_loader #(.N(N), .W(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .abort(abort), .mat_a(mat_a), .mat_b(mat_b),
    .mat_valid(mat_valid), .mat_ready(mat_ready), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int pairs_seen = 0;

  // Reference model: frame byte list, drain flag, presented pair.
  logic [7:0]    frame_q[$];
  bit            m_drain = 0;
  bit            m_ready = 0;
  bit            m_valid = 0;
  bit            m_err = 0;
  bit            m_acc = 0;
  logic [BW-1:0] m_a = '0, m_b = '0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_drain = 0; m_ready = 0; m_valid = 0; m_err = 0; m_a = '0; m_b = '0;
  endtask

  task automatic compare_all();
    chk("s_ready", BW'(s_ready), BW'(m_ready));
    chk("mat_valid", BW'(mat_valid), BW'(m_valid));
    chk("err", BW'(err), BW'(m_err));
    if (m_valid) begin
      chk("mat_a", mat_a, m_a);
      chk("mat_b", mat_b, m_b);
    end
    if (err) err_seen++;
  endtask

  // One clock cycle: drive, advance, update model, compare.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit ab, input bit mr);
    bit valid_pre;
    s_valid = v; s_data = d; s_last = l; abort = ab; mat_ready = mr;
    @(posedge clk);
    #1;
    valid_pre = m_valid;
    m_err = 0;
    m_acc = 0;
    if (ab) begin
      frame_q.delete();
      m_drain = 0;
      m_valid = 0;
    end else if (m_valid) begin
      if (mr) m_valid = 0;
    end else if (v && m_ready) begin
      m_acc = 1;
      if (m_drain) begin
        if (l) m_drain = 0;
      end else if (l && frame_q.size() < 2 * NN - 1) begin
        m_err = 1;
        frame_q.delete();
      end else begin
        frame_q.push_back(d);
        if (frame_q.size() == 2 * NN) begin
          if (l) begin
            for (int i = 0; i < NN; i++) begin
              m_a[i*8 +: 8] = frame_q[i];
              m_b[i*8 +: 8] = frame_q[NN + i];
            end
            m_valid = 1;
          end else begin
            m_err = 1;
            m_drain = 1;
          end
          frame_q.delete();
        end
      end
    end
    m_ready = !m_valid;
    if (m_valid && !valid_pre) pairs_seen++;
    compare_all();
  endtask

  // Offer one byte until the model accepts it (bounded).
  task automatic send(input logic [7:0] d, input bit l);
    int n = 0;
    do begin
      step(1, d, l, 0, 0);
      n++;
    end while (!m_acc && n < 20);
    chk("send_timeout", BW'(m_acc), BW'(1));
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 2 * NN; i++) send(base + 8'(i), i == 2 * NN - 1);
  endtask

  task automatic release_pair();
    step(0, 8'h00, 0, 0, 1);
  endtask

  initial begin
    logic [BW-1:0] hold_a, hold_b;
    int e0, p0;

    // Reset state
    model_reset();
    #12;
    compare_all();
    chk("reset_mat_a", mat_a, '0);
    chk("reset_mat_b", mat_b, '0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 8'h00, 0, 0, 0);

    // Nominal frame 01..08
    e0 = err_seen;
    send_frame(8'h01);
    chk("nominal_valid", BW'(mat_valid), BW'(1));
    chk("nominal_a", mat_a, 32'h04030201);
    chk("nominal_b", mat_b, 32'h08070605);

    // Backpressure for 5 cycles, buses stable
    hold_a = mat_a; hold_b = mat_b;
    repeat (5) step(1, 8'hee, 0, 0, 0);
    chk("bp_a_stable", mat_a, hold_a);
    chk("bp_b_stable", mat_b, hold_b);
    release_pair();
    chk("release_valid", BW'(mat_valid), BW'(0));
    chk("release_ready", BW'(s_ready), BW'(1));
    chk("nominal_no_err", BW'(err_seen - e0), BW'(0));

    // Early last on the third byte, then clean 11..18
    e0 = err_seen;
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 1);
    send_frame(8'h11);
    chk("early_a", mat_a, 32'h14131211);
    chk("early_b", mat_b, 32'h18171615);
    chk("early_err_count", BW'(err_seen - e0), BW'(1));
    release_pair();

    // Missing last, drain two bytes, then clean frame
    e0 = err_seen; p0 = pairs_seen;
    for (int i = 0; i < 2 * NN; i++) send(8'h30 + 8'(i), 0);
    chk("missing_no_valid", BW'(mat_valid), BW'(0));
    send(8'h40, 0); send(8'h41, 1);
    chk("missing_no_pair", BW'(pairs_seen - p0), BW'(0));
    send_frame(8'h21);
    chk("missing_err_count", BW'(err_seen - e0), BW'(1));
    chk("missing_clean_a", mat_a, 32'h24232221);
    chk("missing_clean_b", mat_b, 32'h28272625);
    release_pair();

    // Abort after the 6th byte, then clean frame
    e0 = err_seen; p0 = pairs_seen;
    for (int i = 0; i < 6; i++) send(8'h50 + 8'(i), 0);
    step(1, 8'h56, 0, 1, 0);
    send_frame(8'h61);
    chk("abort_pairs", BW'(pairs_seen - p0), BW'(1));
    chk("abort_no_err", BW'(err_seen - e0), BW'(0));
    chk("abort_clean_a", mat_a, 32'h64636261);
    // Abort while presenting with mat_ready high drops the pair
    step(0, 8'h00, 0, 1, 1);
    chk("abort_present_valid", BW'(mat_valid), BW'(0));

    // Reset while presenting
    send_frame(8'h71);
    chk("pre_rst_valid", BW'(mat_valid), BW'(1));
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_mat_a", mat_a, '0);
    chk("rst_mat_b", mat_b, '0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    step(0, 8'h00, 0, 0, 0);
    chk("rst_ready_after", BW'(s_ready), BW'(1));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit v, l, ab, mr;
      v  = ($urandom_range(0, 3) != 0);
      l  = (frame_q.size() == 2 * NN - 1) ? ($urandom_range(0, 7) != 0)
                                          : ($urandom_range(0, 19) == 0);
      ab = ($urandom_range(0, 59) == 0);
      mr = ($urandom_range(0, 1) == 1);
      step(v, 8'($urandom), l, ab, mr);
    end
    chk("random_pairs_nonzero", BW'(pairs_seen > 5), BW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
